spi_port_expander: RTL
======================

Name: spi_port_expander

Overview:
- Parametrised SPI slave port expander for the front-panel ASIC; next generation of the single-LED-port SPI slave.
- Receives a command word followed by a data word. Drives NUM_PORTS output ports of WORD_W bits each and returns identity and status words.
- Sits between the host CPU SPI master and the front-panel LED/indicator drivers. All logic runs in the SPI clock domain.

Parameters:
- WORD_W, 8: bits per SPI word and per port. Minimum 8.
- NUM_PORTS, 4: number of output ports. Range 1..2^(WORD_W-3).
- CHIP_ID, 'h72: word returned for READ_CHIP_ID.
- VENDOR_ID, 'hAE: word returned for READ_VENDOR_ID.
- ACK, 'h01: response to a legal command.
- NAK, 'h80: response to an illegal command or an out-of-range index.

Ports:
- SCLK  input  1  SPI serial clock. This is the only clock.
- NRST  input  1  reset, asynchronous and active-high.
- SS  input  1  slave select, active low.
- MOSI  input  1  serial data in.
- MISO  output  1  serial data out.
- PORTS  output  NUM_PORTS*WORD_W  flattened port registers. Port n occupies [n*WORD_W +: WORD_W].
- BYTE_IN  output  1  word-complete strobe.
- CMD_ERR  output  1  sticky error flag.

Behaviour:
- NRST high clears, immediately: bit counter, rx shift register, tx register, phase (set to CMD), MISO, BYTE_IN, CMD_ERR and all PORTS to 0. Reset mid-word discards the partial word.
- SCLK edges with SS high are ignored: no shift, no count, and MISO holds.
- Every posedge SCLK with SS low:
  - rx <= {MOSI, rx[WORD_W-1:1]}, so words are LSB first.
  - MISO <= tx[bitcnt].
  - bitcnt increments.
- Word completes on the posedge where bitcnt == WORD_W-1. On that edge:
  - bitcnt -> 0.
  - The completed word is W = {MOSI, rx[WORD_W-1:1]}.
  - BYTE_IN goes high for exactly that one SCLK cycle, then clears on the next enabled edge.
- Command decode uses op = W[WORD_W-1:WORD_W-3] and idx = W[WORD_W-4:0]. Phase CMD, on word complete:
  - op 000, W=0x00 (NOP): tx=ACK.
  - op 000, W=0x01 (legacy WRITE_PORT 0): tx=ACK.
  - op 000, W=0x06: tx=CHIP_ID.
  - op 000, W=0x19: tx=VENDOR_ID.
  - op 000, any other value: tx=NAK.
  - op 001 (WRITE_PORT idx): tx=ACK if idx<NUM_PORTS, else NAK.
  - op 010 (READ_PORT idx): tx=PORTS[idx] sampled at this edge if idx<NUM_PORTS, else NAK.
  - Any other op: tx=NAK.
  - The command word is latched into DEVCMD and phase -> DATA.
  - Any NAK sets CMD_ERR. It is cleared only by NRST.
- Phase DATA, on word complete:
  - If DEVCMD is a legal write, PORTS[idx] <= W on this same edge.
  - Otherwise W is discarded and no port changes.
  - tx <= 0 and phase -> CMD.
- Latency: the response to a command shifts out during the very next word. The first response bit appears on MISO after the first posedge of that word.
- Simultaneous events:
  - A READ_PORT issued in the frame right after a WRITE to the same port returns the new value.
  - An out-of-range write never corrupts any port.
- Transactions are always exactly 2 words, and there is no framing resync other than NRST.
- Counter widths: bitcnt is clog2(WORD_W) bits. Index compare is unsigned.

Optional Feature:
- Macro READBACK_EN.
  - Defined: op 010 READ_PORT is implemented as above.
  - Undefined: op 010 is treated as illegal, returning NAK and setting CMD_ERR. The readback mux is not synthesised.

Test Plan:
- Reset with NRST=1 mid-word, then release -> PORTS=0, MISO=0, CMD_ERR=0, BYTE_IN=0. The next frame decodes from bit 0.
- Frame 0x06, 0x00, then frame 0x00, 0x00 -> MISO carries 0x72 LSB first in word 2. BYTE_IN pulses once per word (4 pulses total).
- Frame 0x22, 0xA5 (write port 2) -> word-2 MISO = 0x01. PORTS[2]=0xA5, other ports unchanged.
- With READBACK_EN: frame 0x42, 0x00 after the previous write -> word-2 MISO = 0xA5. Without READBACK_EN -> MISO 0x80 and CMD_ERR=1.
- Frame 0x27, 0x3C with NUM_PORTS=4 -> MISO 0x80, all PORTS unchanged, CMD_ERR=1.
- Toggle SCLK with SS=1 for 5 edges mid-frame -> bitcnt, rx and MISO unchanged. The frame completes correctly once SS=0 resumes.

Source files
------------

// File: rtl/spi_port_expander.sv
// rtl/spi_port_expander.sv - SPI slave port expander: command/data word pairs drive NUM_PORTS output ports.
// Optional macro READBACK_EN enables the READ_PORT command (op 010); otherwise op 010 answers NAK.
module spi_port_expander #(
    parameter int                 WORD_W    = 8,
    parameter int                 NUM_PORTS = 4,
    parameter logic [WORD_W-1:0]  CHIP_ID   = 'h72,
    parameter logic [WORD_W-1:0]  VENDOR_ID = 'hAE,
    parameter logic [WORD_W-1:0]  ACK       = 'h01,
    parameter logic [WORD_W-1:0]  NAK       = 'h80
) (
    input  logic                          SCLK,
    input  logic                          NRST,
    input  logic                          SS,
    input  logic                          MOSI,
    output logic                          MISO,
    output logic [NUM_PORTS*WORD_W-1:0]   PORTS,
    output logic                          BYTE_IN,
    output logic                          CMD_ERR
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int IDX_W = WORD_W - 3;
    localparam logic [IDX_W:0] LP_NUM_PORTS = (IDX_W + 1)'(NUM_PORTS);

    typedef enum logic {PH_CMD, PH_DATA} phase_t;

    logic [CNT_W-1:0]  r_bitcnt;
    logic [WORD_W-1:0] r_rx;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_devcmd;
    logic [WORD_W-1:0] r_port [NUM_PORTS];
    logic              r_miso;
    logic              r_byte_in;
    logic              r_cmd_err;
    phase_t            r_phase;
    phase_t            w_phase_next;

    logic              w_done;
    logic [WORD_W-1:0] w_word;
    logic [2:0]        w_op;
    logic [IDX_W-1:0]  w_idx;
    logic              w_idx_ok;
    logic [WORD_W-1:0] w_resp;
    logic              w_nak;
    logic [2:0]        w_dev_op;
    logic [IDX_W-1:0]  w_dev_idx;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;

    assign w_done   = (r_bitcnt == CNT_W'(WORD_W - 1));
    assign w_word   = {MOSI, r_rx[WORD_W-1:1]};
    assign w_op     = w_word[WORD_W-1:WORD_W-3];
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_idx_ok = ({1'b0, w_idx} < LP_NUM_PORTS);

`ifdef READBACK_EN
    logic [WORD_W-1:0] w_rd_data;

    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_idx == IDX_W'(p)) w_rd_data = r_port[p];
        end
    end
`endif

    always_comb begin
        w_resp = NAK;
        w_nak  = 1'b1;
        case (w_op)
            3'b000: begin
                if (w_word == WORD_W'('h00) || w_word == WORD_W'('h01)) begin
                    w_resp = ACK;
                    w_nak  = 1'b0;
                end else if (w_word == WORD_W'('h06)) begin
                    w_resp = CHIP_ID;
                    w_nak  = 1'b0;
                end else if (w_word == WORD_W'('h19)) begin
                    w_resp = VENDOR_ID;
                    w_nak  = 1'b0;
                end
            end
            3'b001: begin
                if (w_idx_ok) begin
                    w_resp = ACK;
                    w_nak  = 1'b0;
                end
            end
            3'b010: begin
`ifdef READBACK_EN
                if (w_idx_ok) begin
                    w_resp = w_rd_data;
                    w_nak  = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    // Legacy 0x01 is the old single-port write and lands on port 0.
    assign w_dev_op  = r_devcmd[WORD_W-1:WORD_W-3];
    assign w_dev_idx = r_devcmd[IDX_W-1:0];
    assign w_wr_en   = ((w_dev_op == 3'b001) && ({1'b0, w_dev_idx} < LP_NUM_PORTS))
                       || (r_devcmd == WORD_W'('h01));
    assign w_wr_idx  = (w_dev_op == 3'b001) ? w_dev_idx : '0;

    always_comb begin
        w_phase_next = r_phase;
        if (!SS && w_done) begin
            w_phase_next = (r_phase == PH_CMD) ? PH_DATA : PH_CMD;
        end
    end

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            r_phase <= PH_CMD;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            r_bitcnt  <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_devcmd  <= '0;
            r_miso    <= 1'b0;
            r_byte_in <= 1'b0;
            r_cmd_err <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) r_port[p] <= '0;
        end else if (!SS) begin
            r_rx      <= w_word;
            r_miso    <= r_tx[r_bitcnt];
            r_byte_in <= w_done;
            if (w_done) begin
                r_bitcnt <= '0;
                if (r_phase == PH_CMD) begin
                    r_tx     <= w_resp;
                    r_devcmd <= w_word;
                    if (w_nak) r_cmd_err <= 1'b1;
                end else begin
                    r_tx <= '0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (w_wr_en && (w_wr_idx == IDX_W'(p))) r_port[p] <= w_word;
                    end
                end
            end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ports
        assign PORTS[g*WORD_W +: WORD_W] = r_port[g];
    end

    assign MISO    = r_miso;
    assign BYTE_IN = r_byte_in;
    assign CMD_ERR = r_cmd_err;

endmodule
